gate_sweep_checker: RTL and testbench
=====================================

# gate_sweep_checker

Self-checking stimulus and capture stage for the two-input logic-gate block. It drives the gate block's `a`/`b` inputs through every input combination and samples its seven gate outputs. Each sample is compared against internally computed expected values, and the block reports a mismatch count, the first failing vector and a pass/fail verdict. It sits directly around the gate block: it is the upstream source of `a`/`b` and the downstream consumer of the gate outputs.

## Interface
- Clocking: one clock, `clk`; reset `rst` is synchronous and active-high.
- `NUM_PASSES`, default 4: number of full sweeps of the 4 input vectors per run; must be ≥1.
- `ERR_W`, default 8: width of the mismatch counter.
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  synchronous active-high reset.
- `start`  input  1  run request; sampled only in IDLE.
- `a`  output  1  operand A to the gate block.
- `b`  output  1  operand B to the gate block.
- `gate_out`  input  7  gate block results, packed {xnor, xor, nor, nand, or, and, not} = bits [6:0].
- `busy`  output  1  high in DRIVE, CHECK and DONE.
- `done`  output  1  one-cycle pulse at end of run.
- `pass`  output  1  1 if last completed run had zero mismatches.
- `err_count`  output  ERR_W  mismatches in the current/last run; saturating.
- `first_err_valid`  output  1  a mismatch has been recorded this run.
- `first_err_vec`  output  2  {a,b} of the first mismatching vector.

## Operation
- Reset values:
  - `a`, `b`, `busy`, `done`, `pass`, `first_err_valid`: 0.
  - `err_count`, `first_err_vec`: 0.
  - FSM: IDLE; vector counter `vec` and pass counter: 0.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - `a`, `b` held 0.
  - `start`=1 → DRIVE. On that transition, clear `err_count`, `first_err_valid`, `first_err_vec`, `vec` and the pass counter.
  - `pass` holds its last verdict.
- DRIVE: `{a,b}` = `vec` (registered outputs), then → CHECK.
- CHECK:
  - `{a,b}` unchanged; `gate_out` is sampled this cycle.
  - Expected value is {~(a^b), a^b, ~(a|b), ~(a&b), a|b, a&b, ~a}, computed from the registered `a`, `b`.
  - On mismatch (any bit): `err_count` += 1, saturating at 2^ERR_W−1. If `first_err_valid`=0, set it to 1 and load `first_err_vec` = {a,b}.
  - Then `vec` += 1, wrapping 3→0; on the wrap, the pass counter += 1.
  - If this was vec=3 of pass NUM_PASSES−1 → DONE, else → DRIVE.
- DONE:
  - `done`=1 for this cycle only.
  - `pass` <= (`err_count` after the final CHECK == 0).
  - → IDLE.
- `start` is ignored outside IDLE.
- `start` held high gives back-to-back runs.
- Reset mid-run abandons the run: all outputs take reset values at that edge and no `done` is issued.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Vector k (0-based, k < 4·NUM_PASSES): DRIVE at cycle 2k+1, CHECK at cycle 2k+2.
- DONE (`done`=1) at cycle 8·NUM_PASSES+1; IDLE at 8·NUM_PASSES+2. With `start` continuously high, the next DRIVE is at 8·NUM_PASSES+3.
- Run period is 8·NUM_PASSES+2 cycles (34 for the default).
- The gate block is combinational: `gate_out` must settle within one cycle of `a`/`b` changing.
- `err_count` and `first_err_*` update on the edge ending CHECK; visible from the next cycle.
- `pass` updates on the edge ending DONE.

## Configuration
- Macro: `GATE_SWEEP_INJECT_EN`.
- Defined:
  - Adds input port `force_err` (1 bit).
  - `force_err`=1 during a CHECK cycle forces that comparison to count as a mismatch, with full counter and first-error update, regardless of `gate_out`.
  - `force_err` is ignored in other states.
- Undefined: the port does not exist and comparison is purely `gate_out` vs expected.

## Test plan
- Ideal gate model, NUM_PASSES=4, `start` pulse at cycle 0 → `done` at cycle 33, `pass`=1, `err_count`=0, `first_err_valid`=0.
- Gate model with AND output stuck-at-0 → mismatch only on vector 2'b11: `err_count`=4, `first_err_vec`=2'b11, `pass`=0.
- `start` held high for 100 cycles → `done` pulses at cycles 33, 67 and 101 (fresh counts each run); `busy` low exactly one cycle between runs.
- `rst` asserted at cycle 10 of a run → next cycle: `busy`=0, `a`=`b`=0, `err_count`=0, FSM IDLE; no `done` follows.
- ERR_W=2 with all gate outputs inverted → 16 mismatches, `err_count` saturates at 3, `first_err_vec`=2'b00, `pass`=0.
- `GATE_SWEEP_INJECT_EN` defined, ideal model, `force_err` high during the CHECK of vector 1 in pass 0 (cycle 4) → `err_count`=1, `first_err_vec`=2'b01, `pass`=0.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Stimulus/capture stage that sweeps a two-input gate block through all {a,b} vectors and checks its outputs.
// Optional macro GATE_SWEEP_INJECT_EN adds a force_err input that forces a mismatch during CHECK.
module gate_sweep_checker #(
  parameter int unsigned NUM_PASSES = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef GATE_SWEEP_INJECT_EN
  input  logic             force_err,
`endif
  output logic             a,
  output logic             b,
  input  logic [6:0]       gate_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [1:0]       first_err_vec
);

  localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int unsigned VEC_W  = 2;
  localparam int unsigned GATE_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                a_q, a_d;
  logic                b_q, b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_count_q, err_count_d;
  logic                first_err_valid_q, first_err_valid_d;
  logic [VEC_W-1:0]    first_err_vec_q, first_err_vec_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;

  logic [GATE_W-1:0]   expected_c;
  logic                mismatch_c;
  logic                last_vec_c;

  // Reference gate results from the operands currently presented to the gate block
  always_comb begin
    expected_c = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q),
                  a_q | b_q, a_q & b_q, ~a_q};
`ifdef GATE_SWEEP_INJECT_EN
    mismatch_c = (gate_out != expected_c) || force_err;
`else
    mismatch_c = (gate_out != expected_c);
`endif
    last_vec_c = (vec_q == VEC_W'(3)) && (pass_cnt_q == PASS_W'(NUM_PASSES - 1));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d           = state_q;
    a_d               = a_q;
    b_d               = b_q;
    pass_d            = pass_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_vec_d   = first_err_vec_q;
    vec_d             = vec_q;
    pass_cnt_d        = pass_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          state_d           = ST_DRIVE;
          err_count_d       = '0;
          first_err_valid_d = 1'b0;
          first_err_vec_d   = '0;
          vec_d             = '0;
          pass_cnt_d        = '0;
        end
      end

      ST_DRIVE: begin
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (mismatch_c) begin
          if (!(&err_count_q)) begin
            err_count_d = err_count_q + ERR_W'(1);
          end
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_vec_d   = {a_q, b_q};
          end
        end
        vec_d = vec_q + VEC_W'(1);
        if (vec_q == VEC_W'(3)) begin
          pass_cnt_d = pass_cnt_q + PASS_W'(1);
        end
        // Operands for the next DRIVE are loaded on this edge so they settle before its CHECK
        if (last_vec_c) begin
          state_d = ST_DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          state_d = ST_DRIVE;
          a_d     = vec_d[1];
          b_d     = vec_d[0];
        end
      end

      ST_DONE: begin
        pass_d  = (err_count_q == '0);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      a_q               <= 1'b0;
      b_q               <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= '0;
      vec_q             <= '0;
      pass_cnt_q        <= '0;
    end else begin
      state_q           <= state_d;
      a_q               <= a_d;
      b_q               <= b_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_vec_q   <= first_err_vec_d;
      vec_q             <= vec_d;
      pass_cnt_q        <= pass_cnt_d;
    end
  end

  assign a               = a_q;
  assign b               = b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_vec   = first_err_vec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: two checker instances (ERR_W=8 and ERR_W=2) around a faultable gate model.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       force_err = 1'b0;
  logic [1:0] mode = 2'd0;

  logic       a1, b1, busy1, done1, pass1, fv1;
  logic [1:0] fev1;
  logic [7:0] err1;
  logic [6:0] gate1;

  logic       a2, b2, busy2, done2, pass2, fv2;
  logic [1:0] fev2;
  logic [1:0] err2;
  logic [6:0] gate2;

  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  typedef struct {
    int unsigned done_cyc;
    logic [7:0]  err;
    logic [1:0]  err2;
    logic        fv;
    logic [1:0]  fev;
    logic        pass;
    logic        busy_after;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: ideal, 1: AND output stuck-at-0, 2: every output inverted
  function automatic logic [6:0] gate_model(input logic a, input logic b, input logic [1:0] m);
    logic [6:0] g;
    g = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
    if (m == 2'd1) g[1] = 1'b0;
    else if (m == 2'd2) g = ~g;
    return g;
  endfunction

  always_comb gate1 = gate_model(a1, b1, mode);
  always_comb gate2 = gate_model(a2, b2, mode);

  gate_sweep_checker #(.NUM_PASSES(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef GATE_SWEEP_INJECT_EN
    .force_err(force_err),
`endif
    .a(a1), .b(b1), .gate_out(gate1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_valid(fv1), .first_err_vec(fev1)
  );

  gate_sweep_checker #(.NUM_PASSES(4), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start),
`ifdef GATE_SWEEP_INJECT_EN
    .force_err(force_err),
`endif
    .a(a2), .b(b2), .gate_out(gate2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_valid(fv2), .first_err_vec(fev2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // Monitor: pops an expectation on each done pulse, then checks pass/busy on the following cycles
  exp_t cur;
  logic post1 = 1'b0;
  logic post2 = 1'b0;
  always @(negedge clk) begin
    if (post1) begin
      chk("pass", 32'(pass1), 32'(cur.pass));
      chk("pass_sat", 32'(pass2), 32'(cur.err2 == 2'd0));
      chk("busy_gap", 32'(busy1), 32'd0);
      post1 = 1'b0;
      post2 = 1'b1;
    end else if (post2) begin
      chk("busy_next", 32'(busy1), 32'(cur.busy_after));
      post2 = 1'b0;
    end
    if (!rst && done1) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        cur = q.pop_front();
        chk("done_cycle", cyc, cur.done_cyc);
        chk("err_count", 32'(err1), 32'(cur.err));
        chk("first_err_valid", 32'(fv1), 32'(cur.fv));
        chk("first_err_vec", 32'(fev1), 32'(cur.fev));
        chk("err_count_sat", 32'(err2), 32'(cur.err2));
        chk("done_sat", 32'(done2), 32'd1);
        post1 = 1'b1;
      end
    end
  end

  task automatic push(input int unsigned dc, input logic [7:0] e, input logic [1:0] e2,
                      input logic fv, input logic [1:0] fev, input logic p, input logic ba);
    exp_t x;
    x.done_cyc = dc; x.err = e; x.err2 = e2; x.fv = fv; x.fev = fev; x.pass = p; x.busy_after = ba;
    q.push_back(x);
  endtask

  // Single run: start pulse at cycle 0, done expected at cycle 33
  task automatic run(input logic [1:0] m, input logic [7:0] e, input logic [1:0] e2,
                     input logic fv, input logic [1:0] fev, input logic p);
    mode  = m;
    start = 1'b1;
    push(cyc + 33, e, e2, fv, fev, p, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (38) @(negedge clk);
  endtask

  initial begin
    int unsigned c;
    int unsigned d0;
    repeat (3) @(negedge clk);
    chk("rst_a", 32'(a1), 32'd0);
    chk("rst_b", 32'(b1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_fv", 32'(fv1), 32'd0);
    chk("rst_fev", 32'(fev1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(2'd0, 8'd0, 2'd0, 1'b0, 2'b00, 1'b1);
    run(2'd1, 8'd4, 2'd3, 1'b1, 2'b11, 1'b0);
    run(2'd2, 8'd16, 2'd3, 1'b1, 2'b00, 1'b0);

    // start held high for 100 cycles: three back-to-back runs with fresh counts
    mode  = 2'd1;
    start = 1'b1;
    c = cyc;
    push(c + 33,  8'd4, 2'd3, 1'b1, 2'b11, 1'b0, 1'b1);
    push(c + 67,  8'd4, 2'd3, 1'b1, 2'b11, 1'b0, 1'b1);
    push(c + 101, 8'd4, 2'd3, 1'b1, 2'b11, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    run(2'd0, 8'd0, 2'd0, 1'b0, 2'b00, 1'b1);

    // Reset at cycle 10 of a faulty run abandons it
    mode  = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_err", 32'(err1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_a", 32'(a1), 32'd0);
    chk("mid_rst_b", 32'(b1), 32'd0);
    chk("mid_rst_err", 32'(err1), 32'd0);
    chk("mid_rst_err_sat", 32'(err2), 32'd0);
    chk("mid_rst_pass", 32'(pass1), 32'd0);
    rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy1), 32'd0);
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", done_cnt, d0);

`ifdef GATE_SWEEP_INJECT_EN
    // Forced mismatch during CHECK of vector 1, pass 0 (cycle 4)
    mode  = 2'd0;
    start = 1'b1;
    push(cyc + 33, 8'd1, 2'd1, 1'b1, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    force_err = 1'b1;
    @(negedge clk);
    force_err = 1'b0;
    repeat (36) @(negedge clk);
`endif

    run(2'd0, 8'd0, 2'd0, 1'b0, 2'b00, 1'b1);
    repeat (4) @(negedge clk);
    chk("pending_runs", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
